// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for the fetch redirect controller: the state
// encoding, the default reset PC and the word-address type.
package fetch_redirect_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef logic [31:0] word_addr_t;

  // IDLE: sequential fetch; WAIT_DS: target latched, delay slot not yet
  // fetched; PEND: delay slot fetched, target held across a fetch stall.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_DS = 2'd1,
    ST_PEND    = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_redirect_prio.sv
// Combinational priority select of redirect requests and their targets.
// Decode order: branch_taken > is_jr > is_jump.
// With EXC_REDIRECT_EN defined, the exception/eret pair is also selected
// here (exc_valid > is_eret).
module redirect_prio
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            branch_taken,
  input  logic [PC_W-1:0] pcbranch,
  input  logic            is_jr,
  input  logic [PC_W-1:0] pcjr,
  input  logic            is_jump,
  input  logic [PC_W-1:0] pcjump,
`ifdef EXC_REDIRECT_EN
  input  logic            exc_valid,
  input  logic [PC_W-1:0] pcexception,
  input  logic            is_eret,
  input  logic [PC_W-1:0] pc_eret,
  output logic            exc_req,
  output logic [PC_W-1:0] exc_target,
`endif
  output logic            dec_req,
  output logic [PC_W-1:0] dec_target
);

  // Decode-stage redirect: lower-priority requests are simply dropped.
  always_comb begin
    dec_req    = branch_taken | is_jr | is_jump;
    dec_target = '0;
    if (branch_taken)  dec_target = pcbranch;
    else if (is_jr)    dec_target = pcjr;
    else if (is_jump)  dec_target = pcjump;
  end

`ifdef EXC_REDIRECT_EN
  // Exception vector wins over the eret return address.
  always_comb begin
    exc_req    = exc_valid | is_eret;
    exc_target = exc_valid ? pcexception : pc_eret;
  end
`endif

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC redirect controller with MIPS-style branch delay slot handling.
// A decode-stage redirect is applied immediately when its delay slot is
// already fetched and fetch advances; otherwise the target is latched and
// applied once the delay slot has been fetched and fetch is ready.
// Optional feature macro: EXC_REDIRECT_EN (exception / eret redirects with
// fetch flush). Without it the exception ports are absent and flush_f is 0.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_ready,
  input  logic            ds_in_fetch,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] pcbranch,
  input  logic            is_jr,
  input  logic [PC_W-1:0] pcjr,
  input  logic            is_jump,
  input  logic [PC_W-1:0] pcjump,
`ifdef EXC_REDIRECT_EN
  input  logic            exc_valid,
  input  logic [PC_W-1:0] pcexception,
  input  logic            is_eret,
  input  logic [PC_W-1:0] pc_eret,
`endif
  output logic [PC_W-1:0] pc_f,
  output logic [PC_W-1:0] pc_new,
  output logic            flush_f,
  output logic            redirect_pending
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic [PC_W-1:0] pc_seq;
  logic            dec_req;
  logic [PC_W-1:0] dec_target;
`ifdef EXC_REDIRECT_EN
  logic            exc_req;
  logic [PC_W-1:0] exc_target;
`endif

  redirect_prio #(.PC_W(PC_W)) u_prio (
    .branch_taken (branch_taken),
    .pcbranch     (pcbranch),
    .is_jr        (is_jr),
    .pcjr         (pcjr),
    .is_jump      (is_jump),
    .pcjump       (pcjump),
`ifdef EXC_REDIRECT_EN
    .exc_valid    (exc_valid),
    .pcexception  (pcexception),
    .is_eret      (is_eret),
    .pc_eret      (pc_eret),
    .exc_req      (exc_req),
    .exc_target   (exc_target),
`endif
    .dec_req      (dec_req),
    .dec_target   (dec_target)
  );

  // Next-PC selection and redirect state machine.
  always_comb begin
    pc_seq  = pc_q + PC_W'(4);   // wraps silently at the top of the space
    state_d = state_q;
    tgt_d   = tgt_q;
    pc_d    = fetch_ready ? pc_seq : pc_q;
    case (state_q)
      ST_IDLE: begin
        if (dec_req) begin
          if (ds_in_fetch && fetch_ready) begin
            pc_d = dec_target;
          end else if (!ds_in_fetch) begin
            // Delay slot still has to be fetched first.
            tgt_d   = dec_target;
            pc_d    = pc_seq;
            state_d = ST_WAIT_DS;
          end else begin
            // Delay slot is in fetch but fetch is stalled: hold the target.
            tgt_d   = dec_target;
            pc_d    = pc_q;
            state_d = ST_PEND;
          end
        end
      end
      // The delay slot cannot itself redirect, so decode requests are
      // ignored while a target is outstanding.
      ST_WAIT_DS: begin
        pc_d = pc_q;
        if (fetch_ready) begin
          pc_d    = tgt_q;
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        pc_d = pc_q;
        if (fetch_ready) begin
          pc_d    = tgt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef EXC_REDIRECT_EN
    // Exceptions and eret override everything, including stalls.
    if (exc_req) begin
      pc_d    = exc_target;
      state_d = ST_IDLE;
    end
`endif
  end

  // State, PC and latched-target registers; reset discards any pending redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  assign pc_f             = pc_q;
  assign pc_new           = pc_d;
  assign redirect_pending = (state_q != ST_IDLE);
`ifdef EXC_REDIRECT_EN
  assign flush_f          = exc_req & ~reset;
`else
  assign flush_f          = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: a driver applies stimulus on
// the falling edge and pushes the reference model's expectations; a monitor
// pops and compares them shortly afterwards.
module tb_fetch_redirect_ctrl;
  import fetch_redirect_ctrl_pkg::*;

  localparam word_addr_t RST_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, fetch_ready = 1'b0, ds_in_fetch = 1'b0;
  logic        branch_taken = 1'b0, is_jr = 1'b0, is_jump = 1'b0;
  logic [31:0] pcbranch = '0, pcjr = '0, pcjump = '0;
`ifdef EXC_REDIRECT_EN
  logic        exc_valid = 1'b0, is_eret = 1'b0;
  logic [31:0] pcexception = '0, pc_eret = '0;
`endif
  logic [31:0] pc_f, pc_new;
  logic        flush_f, redirect_pending;

  fetch_redirect_ctrl #(.PC_W(32), .RESET_PC(32'hBFC0_0000)) dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_ready      (fetch_ready),
    .ds_in_fetch      (ds_in_fetch),
    .branch_taken     (branch_taken),
    .pcbranch         (pcbranch),
    .is_jr            (is_jr),
    .pcjr             (pcjr),
    .is_jump          (is_jump),
    .pcjump           (pcjump),
`ifdef EXC_REDIRECT_EN
    .exc_valid        (exc_valid),
    .pcexception      (pcexception),
    .is_eret          (is_eret),
    .pc_eret          (pc_eret),
`endif
    .pc_f             (pc_f),
    .pc_new           (pc_new),
    .flush_f          (flush_f),
    .redirect_pending (redirect_pending)
  );

  typedef struct {
    logic [31:0] pc_f;
    logic [31:0] pc_new;
    logic        pend;
    logic        flush;
    bit          dchk;
    logic [31:0] dpc;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model: a single "outstanding target" slot.
  logic [31:0] m_pc  = RST_PC;
  logic [31:0] m_tgt = '0;
  bit          m_has = 1'b0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp, int tag);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s tag=%0d actual=%h expected=%h", nm, tag, act, exp);
  endtask

  // One clock of stimulus plus the model's expectation for that cycle.
  task automatic cyc(bit r = 0, bit fr = 0, bit ds = 0,
                     bit bt = 0, logic [31:0] pb = 0,
                     bit jr = 0, logic [31:0] pj = 0,
                     bit jp = 0, logic [31:0] pjp = 0,
                     bit ex = 0, logic [31:0] pex = 0,
                     bit er = 0, logic [31:0] per = 0,
                     int tag = 0, bit dchk = 0, logic [31:0] dpc = 0);
    exp_t        e;
    bit          dec, fire, n_has;
    logic [31:0] dt, nxt, n_tgt;
    @(negedge clk);
    reset = r; fetch_ready = fr; ds_in_fetch = ds;
    branch_taken = bt; pcbranch = pb; is_jr = jr; pcjr = pj;
    is_jump = jp; pcjump = pjp;
`ifdef EXC_REDIRECT_EN
    exc_valid = ex; pcexception = pex; is_eret = er; pc_eret = per;
    fire = ex | er;
`else
    fire = 1'b0;
`endif
    if (r) begin m_pc = RST_PC; m_has = 0; m_tgt = '0; end
    dec = bt | jr | jp;
    dt  = bt ? pb : (jr ? pj : pjp);
    n_has = m_has; n_tgt = m_tgt;
    e.pc_f = m_pc; e.pend = m_has; e.flush = 1'b0;
    e.tag = tag; e.dchk = dchk; e.dpc = dpc;
    if (fire) begin
      nxt = ex ? pex : per; e.flush = !r; n_has = 0;
    end else if (m_has) begin
      nxt = fr ? m_tgt : m_pc;
      if (fr) n_has = 0;
    end else if (dec) begin
      if (ds && fr)  nxt = dt;
      else if (!ds) begin nxt = m_pc + 32'd4; n_has = 1; n_tgt = dt; end
      else          begin nxt = m_pc;         n_has = 1; n_tgt = dt; end
    end else begin
      nxt = fr ? m_pc + 32'd4 : m_pc;
    end
    e.pc_new = nxt;
    sb.push_back(e);
    if (!r) begin m_pc = nxt; m_has = n_has; m_tgt = n_tgt; end
  endtask

  // Monitor: compares every presented cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc_f", pc_f, e.pc_f, e.tag);
        check("pc_new", pc_new, e.pc_new, e.tag);
        check("redirect_pending", {31'b0, redirect_pending}, {31'b0, e.pend}, e.tag);
        check("flush_f", {31'b0, flush_f}, {31'b0, e.flush}, e.tag);
        if (e.dchk) check("pc_f_directed", pc_f, e.dpc, e.tag);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    checks++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    // Reset state.
    cyc(.r(1), .tag(1), .dchk(1), .dpc(32'hBFC0_0000));
    cyc(.r(1), .fr(1), .tag(2), .dchk(1), .dpc(32'hBFC0_0000));
    // First cycle after release still presents the reset PC.
    cyc(.fr(1), .ds(1), .jp(1), .pjp(32'h100), .tag(3), .dchk(1), .dpc(32'hBFC0_0000));
    // Branch with delay slot not yet fetched.
    cyc(.fr(1), .bt(1), .pb(32'h200), .tag(10), .dchk(1), .dpc(32'h100));
    cyc(.fr(1), .tag(11), .dchk(1), .dpc(32'h104));
    cyc(.fr(1), .tag(12), .dchk(1), .dpc(32'h200));
    // Branch beats jump in the same cycle.
    cyc(.fr(1), .ds(1), .bt(1), .pb(32'h300), .jp(1), .pjp(32'h400), .tag(20));
    cyc(.fr(1), .tag(21), .dchk(1), .dpc(32'h300));
    // jr held across a three-cycle stall.
    cyc(.ds(1), .jr(1), .pj(32'h500), .tag(30));
    cyc(.ds(1), .tag(31), .dchk(1), .dpc(32'h304));
    cyc(.ds(1), .tag(32), .dchk(1), .dpc(32'h304));
    cyc(.fr(1), .tag(33), .dchk(1), .dpc(32'h304));
    cyc(.fr(1), .tag(34), .dchk(1), .dpc(32'h500));
    // PC+4 wrap.
    cyc(.fr(1), .ds(1), .jp(1), .pjp(32'hFFFF_FFFC), .tag(40));
    cyc(.fr(1), .tag(41), .dchk(1), .dpc(32'hFFFF_FFFC));
    cyc(.fr(1), .tag(42), .dchk(1), .dpc(32'h0));
    // Reset in the middle of WAIT_DS.
    cyc(.fr(1), .jp(1), .pjp(32'h800), .tag(50));
    cyc(.r(1), .tag(51), .dchk(1), .dpc(32'hBFC0_0000));
    cyc(.r(1), .fr(1), .tag(52));
    cyc(.fr(1), .tag(53), .dchk(1), .dpc(32'hBFC0_0000));
`ifdef EXC_REDIRECT_EN
    // Exception during WAIT_DS with fetch stalled.
    cyc(.fr(1), .jp(1), .pjp(32'h900), .tag(60));
    cyc(.ex(1), .pex(32'hBFC0_0380), .er(1), .per(32'h1234), .tag(61));
    cyc(.tag(62), .dchk(1), .dpc(32'hBFC0_0380));
    cyc(.fr(1), .er(1), .per(32'h2000), .ds(1), .bt(1), .pb(32'h40), .tag(63));
    cyc(.fr(1), .tag(64), .dchk(1), .dpc(32'h2000));
`endif
    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      cyc(.r($urandom_range(0, 59) == 0),
          .fr($urandom_range(0, 3) != 0),
          .ds($urandom_range(0, 1) == 1),
          .bt($urandom_range(0, 5) == 0), .pb($urandom & 32'hFFFF_FFFC),
          .jr($urandom_range(0, 5) == 0), .pj($urandom & 32'hFFFF_FFFC),
          .jp($urandom_range(0, 5) == 0), .pjp($urandom & 32'hFFFF_FFFC),
          .ex($urandom_range(0, 24) == 0), .pex($urandom & 32'hFFFF_FFFC),
          .er($urandom_range(0, 24) == 0), .per($urandom & 32'hFFFF_FFFC),
          .tag(1000 + i));
    end
    @(negedge clk);
    @(negedge clk);
    #3;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'hBFC0_0000, PC loaded at reset.
REQ-002 Parameter PC_W, 32, PC width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 fetch_ready  in  1  fetch stage accepts pc_f this cycle; low = stall.
REQ-006 ds_in_fetch  in  1  delay-slot instruction of the decode-stage control transfer is already in the fetch register.
REQ-007 branch_taken / pcbranch  in  1 / PC_W  resolved taken branch and target.
REQ-008 is_jr / pcjr  in  1 / PC_W  register jump and target.
REQ-009 is_jump / pcjump  in  1 / PC_W  direct jump and target.
REQ-010 exc_valid / pcexception  in  1 / PC_W  exception redirect and vector (EXC_REDIRECT_EN only).
REQ-011 is_eret / pc_eret  in  1 / PC_W  return-from-exception and EPC (EXC_REDIRECT_EN only).
REQ-012 pc_f  out  PC_W  PC currently presented to fetch.
REQ-013 pc_new  out  PC_W  next PC the fetch register loads.
REQ-014 flush_f  out  1  kill the instruction in the fetch register.
REQ-015 redirect_pending  out  1  a latched target is waiting to be applied.

Function
REQ-016 Decode redirect priority: branch_taken > is_jr > is_jump; lower-priority requests in the same cycle are ignored.
REQ-017 States: IDLE, WAIT_DS (target latched, delay slot not yet fetched), PEND (delay slot fetched, target held across stall).
REQ-018 IDLE, decode redirect, ds_in_fetch=1, fetch_ready=1: pc_new = target; pc_f = target next cycle; stay IDLE.
REQ-019 IDLE, decode redirect, ds_in_fetch=0: latch target; pc_new = pc_f+4 (fetch the delay slot); go WAIT_DS.
REQ-020 IDLE, decode redirect, ds_in_fetch=1, fetch_ready=0: latch target; go PEND.
REQ-021 WAIT_DS: on fetch_ready, pc_new = latched target, go IDLE; new decode redirects are ignored (delay slot cannot be a control transfer).
REQ-022 PEND: hold; on first fetch_ready cycle apply latched target, go IDLE.
REQ-023 No redirect, fetch_ready=1: pc_new = pc_f+4; fetch_ready=0: pc_new = pc_f (hold).
REQ-024 PC+4 wraps modulo 2^PC_W; no overflow indication.
REQ-025 redirect_pending = 1 exactly in WAIT_DS and PEND.
REQ-026 flush_f = 0 in all cases except REQ-028.
REQ-027 Latched target and state change only on the edge; redirect to target takes effect one cycle after acceptance.

Reset
REQ-028 On reset assertion, immediately: pc_f = RESET_PC, state IDLE, latched target = 0, redirect_pending = 0, flush_f = 0; a pending redirect mid-operation is discarded.
REQ-029 First fetch after reset release presents RESET_PC for at least one cycle.

Configuration
REQ-030 Macro EXC_REDIRECT_EN defined: exc_valid > is_eret > decode redirects; either forces pc_new = its target regardless of fetch_ready and state, asserts flush_f that cycle, clears pending state to IDLE.
REQ-031 Macro undefined: exc_valid/is_eret/pcexception/pc_eret ports absent; flush_f tied 0.

Structure
REQ-032 Shared package common holds the state enum typedef, RESET_PC default and the word-address typedef.
REQ-033 One sub-module, redirect_prio, purely combinational priority select of request/target.

Verification
REQ-034 Reset asserted mid-WAIT_DS -> pc_f=32'hBFC0_0000, redirect_pending=0 immediately.
REQ-035 pc_f=0x100, branch_taken, pcbranch=0x200, ds_in_fetch=0 -> pc_f 0x104 then 0x200; redirect_pending high one cycle.
REQ-036 branch_taken (0x300) and is_jump (0x400) same cycle, ds_in_fetch=1 -> pc_f=0x300.
REQ-037 is_jr pcjr=0x500, ds_in_fetch=1, fetch_ready low 3 cycles -> PEND, pc_f held; pc_f=0x500 after fetch_ready rises.
REQ-038 pc_f=0xFFFF_FFFC, no redirect -> pc_f=0x0000_0000.
REQ-039 EXC_REDIRECT_EN: exc_valid with pcexception=0xBFC0_0380 during WAIT_DS and fetch_ready=0 -> flush_f=1, pc_f=0xBFC0_0380 next cycle, state IDLE.
